// File: rtl/rr_mux_nbit_if.sv
// Channel-side and output-side bus of the round-robin N-bit multiplexer.
// in_last exists only when RR_MUX_LOCK_EN is defined (packet lock build).
interface rr_mux_nbit_if #(
  parameter int N  = 64,
  parameter int M  = 4,
  parameter int SW = $clog2(M)
) ();

  logic [M-1:0]   in_valid;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef RR_MUX_LOCK_EN
  logic [M-1:0]   in_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/rr_mux_nbit.sv
// Round-robin M-channel to one N-bit multiplexer with a single-entry output register.
// Define RR_MUX_LOCK_EN to add per-channel in_last and hold the grant until a packet ends.
module rr_mux_nbit #(
  parameter int N  = 64,
  parameter int M  = 4,
  parameter int SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_mux_nbit_if.slave   bus
);

  logic [SW-1:0] ptr_r;
  logic          out_valid_r;
  logic [N-1:0]  out_data_r;
  logic [SW-1:0] out_sel_r;

  logic          load_en_s;
  logic          grant_found_s;
  logic [SW-1:0] grant_idx_s;
  logic          accept_s;
  logic [M-1:0]  req_s;
  logic [M-1:0]  in_ready_s;
  logic [N-1:0]  sel_data_s;

  // First requester after 'last', wrapping modulo M; MSB of the result flags a hit.
  function automatic logic [SW:0] rr_pick(input logic [M-1:0] req, input logic [SW-1:0] last);
    logic          found;
    logic          hit;
    logic [SW-1:0] idx;
    int            c;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= M; i++) begin
      c     = (int'(last) + i) % M;
      hit   = !found && req[c];
      idx   = hit ? SW'(c) : idx;
      found = found | hit;
    end
    return {found, idx};
  endfunction

`ifdef RR_MUX_LOCK_EN
  logic          lock_r;
  logic [SW-1:0] lock_ch_r;

  // While locked, only the locked channel may request.
  always_comb begin
    req_s = '0;
    for (int k = 0; k < M; k++) begin
      req_s[k] = bus.in_valid[k] & (!lock_r | (lock_ch_r == SW'(k)));
    end
  end

  // Lock follows the in_last flag of every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_r    <= 1'b0;
      lock_ch_r <= '0;
    end else if (accept_s) begin
      lock_r    <= !bus.in_last[grant_idx_s];
      lock_ch_r <= grant_idx_s;
    end
  end
`else
  // Per-beat arbitration: every valid channel competes.
  always_comb begin
    req_s = bus.in_valid;
  end
`endif

  // Grant, handshake and data selection; in_ready is held low while reset is asserted.
  always_comb begin
    load_en_s                    = !out_valid_r || bus.out_ready;
    {grant_found_s, grant_idx_s} = rr_pick(req_s, ptr_r);
    accept_s                     = rst_n && load_en_s && grant_found_s;
    in_ready_s                   = '0;
    sel_data_s                   = '0;
    for (int k = 0; k < M; k++) begin
      in_ready_s[k] = accept_s && (grant_idx_s == SW'(k));
      sel_data_s    = sel_data_s | ({N{grant_idx_s == SW'(k)}} & bus.in_data[k*N +: N]);
    end
  end

  // Output register and round-robin pointer; a stalled beat keeps everything frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sel_r   <= '0;
      ptr_r       <= SW'(M - 1);
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_sel_r   <= grant_idx_s;
      ptr_r       <= grant_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;

endmodule
